// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_controller
//  Brief    : Load-use / branch-flush / mult-div structural hazard control for
//             the 5-stage MIPS core. Define HAZARD_PERF_CNT_EN to build the
//             stall and flush performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_controller #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           IF_ID_rs,
    input  logic [4:0]           IF_ID_rt,
    input  logic                 IF_ID_uses_rt,
    input  logic                 ID_EX_MemRead,
    input  logic [4:0]           ID_EX_rt,
    input  logic                 ID_md_op,
    input  logic                 ID_md_read,
    input  logic                 EX_branch_taken,
    output logic                 PC_Write,
    output logic                 IF_ID_Write,
    output logic                 IF_ID_Flush,
    output logic                 ID_EX_Flush,
    output logic                 md_start,
    output logic                 md_busy,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam int                 c_ctr_w   = $clog2(MD_LATENCY + 1);
    localparam logic [c_ctr_w-1:0] c_lat_m1  = c_ctr_w'(MD_LATENCY - 1);
    localparam logic [0:0]         c_st_idle = 1'b0;
    localparam logic [0:0]         c_st_busy = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_ctr_w-1:0] r_md_cnt;
    logic [c_ctr_w-1:0] w_md_cnt_nxt;
    logic               w_load_use;
    logic               w_md_struct;

    assign md_busy     = (r_state == c_st_busy);
    assign w_load_use  = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
                         ((ID_EX_rt == IF_ID_rs) ||
                          (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));
    assign w_md_struct = md_busy && (ID_md_op || ID_md_read);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        md_start     = 1'b0;
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;

        if (reset) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (EX_branch_taken) begin
            // ID instruction is squashed, so any stall or issue it wanted is dropped
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (w_load_use || w_md_struct) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else begin
            md_start = ID_md_op && !md_busy;
        end

        // An in-flight mult/div is older than any branch and always completes
        case (r_state)
            c_st_idle: begin
                if (md_start) begin
                    w_state_nxt  = c_st_busy;
                    w_md_cnt_nxt = c_lat_m1;
                end
            end
            c_st_busy: begin
                if (r_md_cnt == '0) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_md_cnt_nxt = r_md_cnt - c_ctr_w'(1);
                end
            end
            default: begin
                w_state_nxt  = c_st_idle;
                w_md_cnt_nxt = '0;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!PC_Write && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
            if (EX_branch_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_controller
//  Brief    : Directed + randomized bench for hazard_controller against a
//             behavioural model (remaining-busy-cycles view of mult/div).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    localparam int L = 4;
    localparam int W = 4;
    localparam int C_SAT = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   IF_ID_rs, IF_ID_rt, ID_EX_rt;
    logic         IF_ID_uses_rt, ID_EX_MemRead, ID_md_op, ID_md_read, EX_branch_taken;
    logic         PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, md_start, md_busy;
    logic [W-1:0] stall_count, flush_count;

    int tests = 0;
    int fails = 0;

    // Model state: cycles the mult/div unit still has to be busy, and raw event counts
    int md_rem = 0;
    int sc_m   = 0;
    int fc_m   = 0;

    hazard_controller #(.MD_LATENCY(L), .CNT_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rt(IF_ID_uses_rt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt),
        .ID_md_op(ID_md_op), .ID_md_read(ID_md_read), .EX_branch_taken(EX_branch_taken),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Flush(ID_EX_Flush), .md_start(md_start), .md_busy(md_busy),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef HAZARD_PERF_CNT_EN
        return (n > C_SAT) ? C_SAT : n;
`else
        return (n < 0) ? n : 0;
`endif
    endfunction

    // Compare every cycle at the falling edge, then advance the model to the next rising edge
    always @(negedge clk) begin
        automatic bit busy = (md_rem > 0);
        automatic bit lu   = ID_EX_MemRead && (ID_EX_rt != 0) &&
                             ((ID_EX_rt == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));
        automatic bit ms   = busy && (ID_md_op || ID_md_read);
        automatic bit e_pc, e_ifw, e_iff, e_idf, e_st;
        if (reset) begin
            {e_pc, e_ifw, e_iff, e_idf, e_st} = 5'b00110;
        end else if (EX_branch_taken) begin
            {e_pc, e_ifw, e_iff, e_idf, e_st} = 5'b11110;
        end else if (lu || ms) begin
            {e_pc, e_ifw, e_iff, e_idf, e_st} = 5'b00010;
        end else begin
            {e_pc, e_ifw, e_iff, e_idf, e_st} = {4'b1100, ID_md_op && !busy};
        end
        check("PC_Write",    32'(PC_Write),    32'(e_pc));
        check("IF_ID_Write", 32'(IF_ID_Write), 32'(e_ifw));
        check("IF_ID_Flush", 32'(IF_ID_Flush), 32'(e_iff));
        check("ID_EX_Flush", 32'(ID_EX_Flush), 32'(e_idf));
        check("md_start",    32'(md_start),    32'(e_st));
        check("md_busy",     32'(md_busy),     32'(busy));
        check("stall_count", 32'(stall_count), 32'(exp_cnt(sc_m)));
        check("flush_count", 32'(flush_count), 32'(exp_cnt(fc_m)));
        if (reset) begin
            md_rem = 0; sc_m = 0; fc_m = 0;
        end else begin
            if (!e_pc) sc_m++;
            if (EX_branch_taken) fc_m++;
            if (e_st) md_rem = L;
            else if (md_rem > 0) md_rem--;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IF_ID_rs = 5'd0; IF_ID_rt = 5'd0; IF_ID_uses_rt = 1'b0;
        ID_EX_MemRead = 1'b0; ID_EX_rt = 5'd0;
        ID_md_op = 1'b0; ID_md_read = 1'b0; EX_branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; idle_inputs(); cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        cyc();
        @(negedge clk);
        check("rst_pc",    32'(PC_Write),    32'd0);
        check("rst_iff",   32'(IF_ID_Flush), 32'd1);
        check("rst_busy",  32'(md_busy),     32'd0);
        check("rst_stall", 32'(stall_count), 32'd0);
        cyc();
        reset = 1'b0;

        // Load-use: one bubble, then flow; $0 never stalls
        ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd5; IF_ID_rs = 5'd5;
        @(negedge clk);
        check("lu_pc",  32'(PC_Write),    32'd0);
        check("lu_idf", 32'(ID_EX_Flush), 32'd1);
        cyc();
        ID_EX_MemRead = 1'b0;
        @(negedge clk);
        check("lu_after_pc", 32'(PC_Write), 32'd1);
        cyc();
        ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0;
        @(negedge clk);
        check("lu_r0_pc", 32'(PC_Write), 32'd1);
        cyc();

        // Branch beats a pending load-use stall
        do_reset();
        ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd5; IF_ID_rs = 5'd5; EX_branch_taken = 1'b1;
        @(negedge clk);
        check("br_pc",  32'(PC_Write),    32'd1);
        check("br_iff", 32'(IF_ID_Flush), 32'd1);
        cyc();
        idle_inputs();
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        check("br_flush_cnt", 32'(flush_count), 32'd1);
`else
        check("br_flush_cnt", 32'(flush_count), 32'd0);
`endif
        cyc();

        // Mult then mfhi
        do_reset();
        ID_md_op = 1'b1;
        @(negedge clk);
        check("mul_start", 32'(md_start), 32'd1);
        cyc();
        ID_md_op = 1'b0; ID_md_read = 1'b1;
        for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            check("mfhi_busy",  32'(md_busy),  32'd1);
            check("mfhi_stall", 32'(PC_Write), 32'd0);
            cyc();
        end
        @(negedge clk);
        check("mfhi_free", 32'(md_busy),  32'd0);
        check("mfhi_go",   32'(PC_Write), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
        check("mfhi_stall_cnt", 32'(stall_count), 32'd4);
`else
        check("mfhi_stall_cnt", 32'(stall_count), 32'd0);
`endif
        cyc();

        // Back-to-back mult
        idle_inputs();
        ID_md_op = 1'b1;
        cyc();
        for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            check("b2b_wait", 32'(md_start), 32'd0);
            cyc();
        end
        @(negedge clk);
        check("b2b_start", 32'(md_start), 32'd1);
        cyc();
        ID_md_op = 1'b0;
        for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            check("b2b_busy", 32'(md_busy), 32'd1);
            cyc();
        end
        @(negedge clk);
        check("b2b_done", 32'(md_busy), 32'd0);
        cyc();

        // Squashed issue
        ID_md_op = 1'b1; EX_branch_taken = 1'b1;
        @(negedge clk);
        check("sq_start", 32'(md_start), 32'd0);
        cyc();
        idle_inputs();
        @(negedge clk);
        check("sq_busy", 32'(md_busy), 32'd0);
        cyc();

        // Reset mid-BUSY
        ID_md_op = 1'b1;
        cyc();
        ID_md_op = 1'b0;
        cyc();
        reset = 1'b1;
        @(negedge clk);
        check("rmb_pc",  32'(PC_Write),    32'd0);
        check("rmb_idf", 32'(ID_EX_Flush), 32'd1);
        cyc();
        @(negedge clk);
        check("rmb_busy",  32'(md_busy),     32'd0);
        check("rmb_stall", 32'(stall_count), 32'd0);
        cyc();
        reset = 1'b0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 79) == 0);
            ID_EX_MemRead   = ($urandom_range(0, 2) == 0);
            ID_EX_rt        = 5'($urandom_range(0, 3));
            IF_ID_rs        = 5'($urandom_range(0, 3));
            IF_ID_rt        = 5'($urandom_range(0, 3));
            IF_ID_uses_rt   = 1'($urandom_range(0, 1));
            ID_md_op        = ($urandom_range(0, 3) == 0);
            ID_md_read      = ($urandom_range(0, 4) == 0);
            EX_branch_taken = ($urandom_range(0, 7) == 0);
            cyc();
        end
        reset = 1'b0;
        idle_inputs();
        cyc();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
